ps2_lane_decoder: RTL and testbench
===================================

// Module: ps2_lane_decoder
// PURPOSE
//  Parametrised successor to the single-purpose keyboard decoder. Turns the PS/2
//  scancode byte stream (scancode + one-cycle receive strobe from ps2_demo) into
//  per-lane press/release pulses and held levels for NUM_LANES piano lanes.
//  - Decodes F0 break and E0 extended prefixes.
//  - Suppresses typematic repeat makes.
//  - Flags presses of unmapped keys (wrong_key) for the game's lose logic.
// PARAMETERS
//  NUM_LANES   4                              number of lanes (1..8)
//  LANE_CODES  {8'h42,8'h3B,8'h2B,8'h23}      packed 8*NUM_LANES make codes; lane0 = bits[7:0] (D,F,J,K)
//  TIMEOUT     24'd2_500_000                  cycles a pending prefix may wait for its next byte (50 ms @ 50 MHz)
// PORTS
//  clock        in   1          system clock (CLOCK_50)
//  resetn       in   1          asynchronous active-low reset (KEY[0])
//  scancode     in   8          received PS/2 byte, valid only when scan_valid=1
//  scan_valid   in   1          one-cycle strobe per received byte
//  enable       in   1          1 = emit press/wrong_key pulses; 0 = gameplay locked
//  key_press    out  NUM_LANES  one-cycle pulse per lane on first make
//  key_release  out  NUM_LANES  one-cycle pulse per lane on break
//  key_held     out  NUM_LANES  level: lane key currently down
//  any_held     out  1          OR of key_held
//  wrong_key    out  1          one-cycle pulse: non-extended make of an unmapped code
//  break_seen   out  1          one-cycle pulse on any completed break sequence (mapped or not)
// BEHAVIOUR
//  Reset: all outputs 0, FSM=IDLE, timeout counter 0. Asserting resetn mid-prefix
//   discards the prefix; held state is lost (no release pulses).
//  FSM (advances only on scan_valid=1):
//   IDLE:  F0->BRK; E0->EXT; other byte = make code.
//   BRK:   any byte = break code -> IDLE.
//   EXT:   F0->EXT_BRK; other byte = extended make, ignored -> IDLE.
//   EXT_BRK: any byte = extended break, ignored except break_seen -> IDLE.
//  Timeout: in BRK/EXT/EXT_BRK a counter increments every cycle without scan_valid.
//   When it reaches TIMEOUT the FSM returns to IDLE with no output.
//   Counter clears on every scan_valid and on entry to IDLE.
//  Lane match: code compared against every LANE_CODES entry. Duplicate entries ->
//   lowest index wins. Code 8'h00 never matches (padding).
//  Make (IDLE, mapped lane i):
//   - key_held[i]=0 -> key_held[i]<=1 and key_press[i]=enable.
//   - key_held[i]=1 (typematic repeat) -> no pulse.
//  Make (IDLE, unmapped, not F0/E0): wrong_key=enable. key_held unchanged.
//  Break (BRK, mapped lane i):
//   - key_held[i]=1 -> key_held[i]<=0 and key_release[i]=1.
//   - key_held[i]=0 -> no pulse.
//   - In all cases break_seen=1.
//  enable gates only key_press and wrong_key. Held tracking and release pulses run
//   regardless, so locking mid-hold leaves no stuck key.
//  Latency: every pulse and key_held change is registered and appears exactly
//   1 cycle after the scan_valid that completes the sequence.
//  At most one lane changes per byte. Pulses are never wider than 1 cycle, even
//   with back-to-back scan_valid.
//  scancode is ignored while scan_valid=0. A prefix byte arriving in BRK or
//   EXT_BRK is treated as the code byte (no nesting).
// TESTING
//  1. Reset, then byte 23 -> key_press=0001 and key_held=0001 one cycle later.
//     Then F0,23 -> key_release=0001, break_seen=1, key_held=0000.
//  2. Typematic: 2B,2B,2B -> exactly one key_press[1] pulse, key_held=0010.
//     Then F0,2B -> one key_release[1].
//  3. Chord: 23,3B,F0,23 -> key_held goes 0001, 0101, 0100. Release pulse only on lane0.
//  4. Wrong/extended: byte 1C -> wrong_key pulse. E0,75 -> no outputs.
//     E0,F0,75 -> only break_seen.
//  5. Lock: enable=0, byte 42 -> key_held[3]=1, no key_press.
//     enable=1, F0,42 -> key_release[3]. Byte 1C with enable=0 -> no wrong_key.
//  6. Timeout/reset:
//     - F0 then idle TIMEOUT cycles, then 23 -> treated as make (key_press[0]).
//     - resetn=0 after F0 -> all outputs 0, next 23 is a make.

Source files
------------

// File: rtl/ps2_lane_decoder.sv
// ps2_lane_decoder: PS/2 scancode stream to per-lane press/release pulses and held levels
module ps2_lane_decoder #(
  parameter int                     NUM_LANES  = 4,
  parameter logic [8*NUM_LANES-1:0] LANE_CODES = {8'h42, 8'h3B, 8'h2B, 8'h23},
  parameter logic [23:0]            TIMEOUT    = 24'd2_500_000
) (
  input  logic                 clock,
  input  logic                 resetn,
  input  logic [7:0]           scancode,
  input  logic                 scan_valid,
  input  logic                 enable,
  output logic [NUM_LANES-1:0] key_press,
  output logic [NUM_LANES-1:0] key_release,
  output logic [NUM_LANES-1:0] key_held,
  output logic                 any_held,
  output logic                 wrong_key,
  output logic                 break_seen
);
  typedef enum logic [1:0] {IDLE, BRK, EXT, EXT_BRK} state_t;
  state_t               state_q, state_d;
  logic [23:0]          cnt_q, cnt_d;
  logic [NUM_LANES-1:0] press_q, press_d, release_q, release_d, held_q, held_d, lane_oh;
  logic                 wrong_q, wrong_d, brk_q, brk_d, hit;
  // Scan high to low so the lowest matching index wins; 8'h00 entries are padding.
  always_comb begin
    lane_oh = '0;
    for (int i = NUM_LANES - 1; i >= 0; i--)
      if (scancode != 8'h00 && scancode == LANE_CODES[8*i +: 8]) begin
        lane_oh = '0;
        lane_oh[i] = 1'b1;
      end
    hit = |lane_oh;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    held_d    = held_q;
    press_d   = '0;
    release_d = '0;
    wrong_d   = 1'b0;
    brk_d     = 1'b0;
    if (scan_valid) begin
      cnt_d = '0;
      case (state_q)
        IDLE: begin
          state_d = scancode == 8'hF0 ? BRK : scancode == 8'hE0 ? EXT : IDLE;
          if (scancode != 8'hF0 && scancode != 8'hE0) begin
            held_d  = held_q | lane_oh;
            press_d = lane_oh & ~held_q & {NUM_LANES{enable}};
            wrong_d = !hit && enable;
          end
        end
        BRK: begin
          release_d = lane_oh & held_q;
          held_d    = held_q & ~lane_oh;
          brk_d     = 1'b1;
          state_d   = IDLE;
        end
        EXT:     state_d = scancode == 8'hF0 ? EXT_BRK : IDLE;
        default: begin
          brk_d   = 1'b1;
          state_d = IDLE;
        end
      endcase
    end else if (state_q != IDLE) begin
      cnt_d = cnt_q + 24'd1;
      if (cnt_d == TIMEOUT) begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    end
  end
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      press_q   <= '0;
      release_q <= '0;
      held_q    <= '0;
      wrong_q   <= 1'b0;
      brk_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      press_q   <= press_d;
      release_q <= release_d;
      held_q    <= held_d;
      wrong_q   <= wrong_d;
      brk_q     <= brk_d;
    end
  end
  assign key_press   = press_q;
  assign key_release = release_q;
  assign key_held    = held_q;
  assign any_held    = |held_q;
  assign wrong_key   = wrong_q;
  assign break_seen  = brk_q;
endmodule

// File: tb/tb_ps2_lane_decoder.sv
// tb_ps2_lane_decoder: directed byte sequences with a per-cycle expectation queue
module tb_ps2_lane_decoder;
  typedef struct packed {
    logic [3:0] p, r, h;
    logic       a, w, b;
  } exp_t;
  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] scancode = 8'h00;
  logic       scan_valid = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] key_press, key_release, key_held;
  logic       any_held, wrong_key, break_seen;
  int         vectors = 0;
  int         miscompares = 0;
  exp_t       q[$];
  localparam int TO = 16;
  ps2_lane_decoder #(.NUM_LANES(4), .LANE_CODES({8'h42, 8'h3B, 8'h2B, 8'h23}), .TIMEOUT(24'd16)) dut (
    .clock(clock), .resetn(resetn), .scancode(scancode), .scan_valid(scan_valid), .enable(enable),
    .key_press(key_press), .key_release(key_release), .key_held(key_held), .any_held(any_held),
    .wrong_key(wrong_key), .break_seen(break_seen)
  );
  always #5 clock = ~clock;
  function automatic exp_t mk(logic [3:0] p, logic [3:0] r, logic [3:0] h, logic w, logic b);
    return {p, r, h, |h, w, b};
  endfunction
  task automatic check(input exp_t e);
    exp_t o;
    o = {key_press, key_release, key_held, any_held, wrong_key, break_seen};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL vec%0d press/rel/held/any/wrong/brk got %h/%h/%h/%b/%b/%b want %h/%h/%h/%b/%b/%b",
             vectors, o.p, o.r, o.h, o.a, o.w, o.b, e.p, e.r, e.h, e.a, e.w, e.b);
    end
  endtask
  // Checks the previous cycle's expectation, then drives this cycle and queues its outcome.
  task automatic cycle(input logic v, input logic [7:0] c, input exp_t e);
    @(negedge clock);
    if (q.size() > 0) check(q.pop_front());
    scan_valid = v;
    scancode   = c;
    q.push_back(e);
  endtask
  task automatic send(input logic [7:0] c, input exp_t e);
    cycle(1'b1, c, e);
  endtask
  task automatic idle(input int n, input logic [3:0] h);
    for (int k = 0; k < n; k++) cycle(1'b0, 8'h00, mk(4'h0, 4'h0, h, 1'b0, 1'b0));
  endtask
  task automatic flush();
    @(negedge clock);
    if (q.size() > 0) check(q.pop_front());
    scan_valid = 1'b0;
  endtask
  initial begin
    repeat (3) @(negedge clock);
    check(mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    resetn = 1'b1;
    // basic make / break
    send(8'h23, mk(4'h1, 4'h0, 4'h1, 1'b0, 1'b0));
    send(8'hF0, mk(4'h0, 4'h0, 4'h1, 1'b0, 1'b0));
    send(8'h23, mk(4'h0, 4'h1, 4'h0, 1'b0, 1'b1));
    idle(1, 4'h0);
    // typematic repeat, back-to-back bytes
    send(8'h2B, mk(4'h2, 4'h0, 4'h2, 1'b0, 1'b0));
    send(8'h2B, mk(4'h0, 4'h0, 4'h2, 1'b0, 1'b0));
    send(8'h2B, mk(4'h0, 4'h0, 4'h2, 1'b0, 1'b0));
    send(8'hF0, mk(4'h0, 4'h0, 4'h2, 1'b0, 1'b0));
    send(8'h2B, mk(4'h0, 4'h2, 4'h0, 1'b0, 1'b1));
    idle(1, 4'h0);
    // chord
    send(8'h23, mk(4'h1, 4'h0, 4'h1, 1'b0, 1'b0));
    send(8'h3B, mk(4'h4, 4'h0, 4'h5, 1'b0, 1'b0));
    send(8'hF0, mk(4'h0, 4'h0, 4'h5, 1'b0, 1'b0));
    send(8'h23, mk(4'h0, 4'h1, 4'h4, 1'b0, 1'b1));
    send(8'hF0, mk(4'h0, 4'h0, 4'h4, 1'b0, 1'b0));
    send(8'h3B, mk(4'h0, 4'h4, 4'h0, 1'b0, 1'b1));
    // wrong key, extended make/break, breaks of unmapped and unheld codes
    send(8'h1C, mk(4'h0, 4'h0, 4'h0, 1'b1, 1'b0));
    send(8'hE0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'h75, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'hE0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'hF0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'h75, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b1));
    send(8'hE0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'h23, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'hF0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'h1C, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b1));
    send(8'hF0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    send(8'h23, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b1));
    // lock gating
    flush();
    enable = 1'b0;
    send(8'h42, mk(4'h0, 4'h0, 4'h8, 1'b0, 1'b0));
    flush();
    enable = 1'b1;
    send(8'hF0, mk(4'h0, 4'h0, 4'h8, 1'b0, 1'b0));
    send(8'h42, mk(4'h0, 4'h8, 4'h0, 1'b0, 1'b1));
    flush();
    enable = 1'b0;
    send(8'h1C, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    flush();
    enable = 1'b1;
    // prefix expires after exactly TO idle cycles
    send(8'hF0, mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    idle(TO, 4'h0);
    send(8'h23, mk(4'h1, 4'h0, 4'h1, 1'b0, 1'b0));
    // one cycle short of expiry the prefix still applies
    send(8'hF0, mk(4'h0, 4'h0, 4'h1, 1'b0, 1'b0));
    idle(TO - 1, 4'h1);
    send(8'h23, mk(4'h0, 4'h1, 4'h0, 1'b0, 1'b1));
    // reset mid-prefix discards prefix and held state
    send(8'h2B, mk(4'h2, 4'h0, 4'h2, 1'b0, 1'b0));
    send(8'hF0, mk(4'h0, 4'h0, 4'h2, 1'b0, 1'b0));
    flush();
    #2 resetn = 1'b0;
    #1 check(mk(4'h0, 4'h0, 4'h0, 1'b0, 1'b0));
    @(negedge clock);
    resetn = 1'b1;
    send(8'h23, mk(4'h1, 4'h0, 4'h1, 1'b0, 1'b0));
    idle(1, 4'h1);
    flush();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
